uart_fifo: RTL and testbench
============================

# uart_fifo

Byte-buffering stage between the peripheral register file and the `uart` core. It queues CPU-written bytes in a TX FIFO and drains them through the `uart` strobe/busy handshake. Received bytes are captured into an RX FIFO using the `uart` ready/clear handshake, so software can tolerate bursts without polling every byte. Everything runs on `raw_clk`, alongside the peripheral and `uart` logic.

## Interface

Parameters:
- `DEPTH_LOG2`, default 4: log2 of each FIFO's depth. Depth is 16 entries, and the count width is `DEPTH_LOG2+1`.

Ports:
- `raw_clk`  input  1  sole clock, rising edge.
- `reset`  input  1  asynchronous, active-low; 0 = reset.
- `tx_write`  input  1  one-cycle push request from the register file.
- `tx_write_data`  input  8  byte to push.
- `rx_read`  input  1  one-cycle pop request.
- `rx_read_data`  output  8  RX head byte, first-word-fall-through; valid when `rx_empty`=0.
- `tx_full`, `tx_empty`  output  1  TX FIFO status.
- `tx_count`  output  DEPTH_LOG2+1  TX occupancy.
- `rx_empty`, `rx_full`  output  1  RX FIFO status.
- `rx_count`  output  DEPTH_LOG2+1  RX occupancy.
- `tx_drop`  output  1  sticky: a push was attempted while TX was full.
- `rx_overflow`  output  1  sticky: a byte was received while RX was full.
- `flag_clear`  input  1  clears `tx_drop` and `rx_overflow`.
- `uart_tx_data`  output  8  byte presented to `uart`.
- `uart_tx_strobe`  output  1  transmit request to `uart`.
- `uart_tx_busy`  input  1  busy indication from `uart`.
- `uart_rx_data`  input  8  received byte from `uart`.
- `uart_rx_ready`  input  1  `uart` has a received byte.
- `uart_rx_ready_clear`  output  1  acknowledge to `uart`.

## Operation

FIFO storage:
- Each FIFO is a circular register array with `DEPTH_LOG2`-bit read and write pointers; pointers wrap from depth-1 to 0.
- Each FIFO has an explicit count register.

Push/pop rules:
- Push when full: ignored. On TX, this sets `tx_drop`.
- Pop when empty: ignored. `rx_read` while `rx_empty` has no effect.
- Simultaneous push and pop on a non-empty, non-full FIFO: both pointers advance and the count is unchanged.
- Push and pop in the same cycle on an empty FIFO: only the push takes effect.
- Push and pop in the same cycle on a full FIFO: both take effect. The pop frees a slot, so the push is accepted.

TX drain FSM:
- TX_IDLE: if `tx_count`≠0 and `uart_tx_busy`=0, drive `uart_tx_data` ← head and `uart_tx_strobe` ← 1, then go to TX_STROBE.
- TX_STROBE: hold the strobe and data. When `uart_tx_busy`=1, set strobe ← 0, pop the head, and go to TX_WAIT.
- TX_WAIT: when `uart_tx_busy`=0, go to TX_IDLE.

RX fill FSM:
- RX_IDLE: when `uart_rx_ready`=1, do the following, then go to RX_ACK:
  - Push `uart_rx_data` if the RX FIFO is not full. If it is full, discard the byte and set `rx_overflow`.
  - Assert `uart_rx_ready_clear`.
- RX_ACK: deassert `uart_rx_ready_clear`. When `uart_rx_ready`=0, go to RX_IDLE.
- Each received byte is pushed exactly once, regardless of how long `uart_rx_ready` stays high.

Sticky flags:
- `flag_clear` has priority over a same-cycle set: both flags read 0 afterwards.

## Timing

Reset values:
- Pointers and counts are 0.
- FSMs are in TX_IDLE and RX_IDLE.
- `uart_tx_strobe`=0, `uart_rx_ready_clear`=0, `uart_tx_data`=0.
- `tx_drop`=0 and `rx_overflow`=0.
- `tx_empty`=1 and `rx_empty`=1; `tx_full`=0 and `rx_full`=0.
- Reset takes effect immediately, including mid-transfer: the strobe drops asynchronously and queued bytes are lost.

Status and data outputs:
- Status outputs are registered and reflect the count after the edge on which a push or pop occurs.
- `rx_read_data` updates in the same cycle the RX pointer or memory changes, with no added latency.

TX latency:
- `tx_write` at edge N on an idle, empty block: `tx_count`=1 after N.
- `uart_tx_strobe`=1 after N+1.
- The pop happens at the first edge where the strobe is high and `uart_tx_busy`=1.

RX latency:
- `uart_rx_ready` rising, sampled at edge M: `rx_count` increments and `uart_rx_ready_clear`=1 after M.
- `uart_rx_ready_clear` is 0 again after M+1. It is a single-cycle pulse.

Other:
- Back-to-back `tx_write` on consecutive cycles is supported: one push per cycle.
- The TX FSM never pops while TX_STROBE has not seen busy, so the data on `uart_tx_data` stays stable while the strobe is high.

## Test plan

- Reset then idle:
  - Stimulus: apply reset, then leave all inputs idle.
  - Required: all outputs hold their reset values; no strobe or ack for 100 cycles.
- TX ordering:
  - Stimulus: push 0x41, 0x42, 0x43 back-to-back. The `uart` model raises busy 2 cycles after the strobe and holds it for 10 cycles.
  - Required: `uart_tx_data` sequence is 0x41, 0x42, 0x43, with exactly one strobe per byte. `tx_count` goes 3 → 0 and `tx_empty` returns to 1.
- TX full:
  - Stimulus: hold `uart_tx_busy`=1 and push 17 bytes, 0x00..0x10.
  - Required: `tx_full`=1 and `tx_count`=16 after the 16th push. The 17th push is dropped and `tx_drop`=1. After busy is released, 0x00..0x0F drain in order and 0x10 is never sent. `flag_clear` then clears `tx_drop`.
- RX capture and read:
  - Stimulus: the `uart` model delivers 0x55, then 0xAA, holding ready until cleared.
  - Required: one `uart_rx_ready_clear` pulse per byte and `rx_count`=2. `rx_read_data`=0x55; after one `rx_read` it is 0xAA; after a second `rx_read`, `rx_empty`=1.
- RX overflow and wrap:
  - Stimulus: deliver 16 bytes with no reads, then deliver 0x99.
  - Required: `rx_full`=1. 0x99 is discarded, `rx_overflow`=1, and the ack is still pulsed.
  - Stimulus: read 4 bytes, deliver 4 more, then read all remaining.
  - Required: correct FIFO order across the pointer wrap.
- Simultaneous events and reset:
  - Stimulus: RX push and `rx_read` in the same cycle at `rx_count`=5.
  - Required: `rx_count` stays 5.
  - Stimulus: assert `reset` while the TX FSM is in TX_STROBE.
  - Required: the strobe falls before the next edge; counts read 0 after reset.

Source files
------------

// File: rtl/uart_fifo.sv
// Byte buffering between the peripheral register file and the uart core:
// a TX FIFO drained through strobe/busy and an RX FIFO filled through ready/clear.

module uart_fifo_buf #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  raw_clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  push_ok_c
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;
    logic [CW-1:0] count_n;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign pop_ok    = pop && !empty;
    assign push_ok_c = push && (!full || pop_ok);
    assign count_n   = count + CW'(push_ok_c) - CW'(pop_ok);
    assign head      = mem[rd_ptr];

    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
        end
    end
endmodule

module uart_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  raw_clk,
    input  logic                  reset,
    input  logic                  tx_write,
    input  logic [7:0]            tx_write_data,
    input  logic                  rx_read,
    output logic [7:0]            rx_read_data,
    output logic                  tx_full,
    output logic                  tx_empty,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  tx_drop,
    output logic                  rx_overflow,
    input  logic                  flag_clear,
    output logic [7:0]            uart_tx_data,
    output logic                  uart_tx_strobe,
    input  logic                  uart_tx_busy,
    input  logic [7:0]            uart_rx_data,
    input  logic                  uart_rx_ready,
    output logic                  uart_rx_ready_clear
);
    localparam logic [1:0] TX_IDLE   = 2'd0;
    localparam logic [1:0] TX_STROBE = 2'd1;
    localparam logic [1:0] TX_WAIT   = 2'd2;
    localparam logic       RX_IDLE   = 1'b0;
    localparam logic       RX_ACK    = 1'b1;

    logic [1:0] tx_state, tx_state_n;
    logic       tx_strobe_n;
    logic [7:0] tx_data_n;
    logic [7:0] tx_head;
    logic       tx_pop_c;
    logic       tx_push_ok_c;
    logic       rx_state, rx_state_n;
    logic       rx_clear_n;
    logic       rx_push_c;
    logic       rx_push_ok_c;

    uart_fifo_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_buf (
        .raw_clk   (raw_clk),
        .reset     (reset),
        .push      (tx_write),
        .push_data (tx_write_data),
        .pop       (tx_pop_c),
        .head      (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty),
        .push_ok_c (tx_push_ok_c)
    );

    uart_fifo_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_buf (
        .raw_clk   (raw_clk),
        .reset     (reset),
        .push      (rx_push_c),
        .push_data (uart_rx_data),
        .pop       (rx_read),
        .head      (rx_read_data),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty),
        .push_ok_c (rx_push_ok_c)
    );

    // TX drain: present head, hold until uart reports busy, then pop.
    always_comb begin
        tx_state_n  = tx_state;
        tx_strobe_n = uart_tx_strobe;
        tx_data_n   = uart_tx_data;
        tx_pop_c    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && !uart_tx_busy) begin
                    tx_data_n   = tx_head;
                    tx_strobe_n = 1'b1;
                    tx_state_n  = TX_STROBE;
                end
            end
            TX_STROBE: begin
                if (uart_tx_busy) begin
                    tx_strobe_n = 1'b0;
                    tx_pop_c    = 1'b1;
                    tx_state_n  = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!uart_tx_busy) tx_state_n = TX_IDLE;
            end
            default: begin
                tx_strobe_n = 1'b0;
                tx_state_n  = TX_IDLE;
            end
        endcase
    end

    // RX fill: one push per ready assertion, single-cycle clear pulse.
    always_comb begin
        rx_state_n = rx_state;
        rx_clear_n = 1'b0;
        rx_push_c  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (uart_rx_ready) begin
                    rx_push_c  = 1'b1;
                    rx_clear_n = 1'b1;
                    rx_state_n = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!uart_rx_ready) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            tx_state            <= TX_IDLE;
            uart_tx_strobe      <= 1'b0;
            uart_tx_data        <= '0;
            rx_state            <= RX_IDLE;
            uart_rx_ready_clear <= 1'b0;
        end else begin
            tx_state            <= tx_state_n;
            uart_tx_strobe      <= tx_strobe_n;
            uart_tx_data        <= tx_data_n;
            rx_state            <= rx_state_n;
            uart_rx_ready_clear <= rx_clear_n;
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            tx_drop     <= 1'b0;
            rx_overflow <= 1'b0;
        end else if (flag_clear) begin
            tx_drop     <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            if (tx_write && !tx_push_ok_c)  tx_drop     <= 1'b1;
            if (rx_push_c && !rx_push_ok_c) rx_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: TX drain ordering, full/drop, RX capture,
// overflow with pointer wrap, simultaneous push/pop and mid-transfer reset.

module tb_uart_fifo;
    logic       raw_clk = 1'b0;
    logic       reset;
    logic       tx_write;
    logic [7:0] tx_write_data;
    logic       rx_read;
    logic [7:0] rx_read_data;
    logic       tx_full, tx_empty, rx_empty, rx_full;
    logic [4:0] tx_count, rx_count;
    logic       tx_drop, rx_overflow, flag_clear;
    logic [7:0] uart_tx_data;
    logic       uart_tx_strobe, uart_tx_busy;
    logic [7:0] uart_rx_data;
    logic       uart_rx_ready, uart_rx_ready_clear;

    logic       hold_busy;
    logic       model_busy;
    logic       model_en;
    int         total = 0;
    int         bad = 0;
    int         strobe_cnt = 0;
    int         ack_cnt = 0;
    logic [7:0] tx_seen[$];

    assign uart_tx_busy = hold_busy | model_busy;

    uart_fifo #(.DEPTH_LOG2(4)) dut (
        .raw_clk(raw_clk), .reset(reset),
        .tx_write(tx_write), .tx_write_data(tx_write_data),
        .rx_read(rx_read), .rx_read_data(rx_read_data),
        .tx_full(tx_full), .tx_empty(tx_empty), .tx_count(tx_count),
        .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count),
        .tx_drop(tx_drop), .rx_overflow(rx_overflow), .flag_clear(flag_clear),
        .uart_tx_data(uart_tx_data), .uart_tx_strobe(uart_tx_strobe),
        .uart_tx_busy(uart_tx_busy), .uart_rx_data(uart_rx_data),
        .uart_rx_ready(uart_rx_ready), .uart_rx_ready_clear(uart_rx_ready_clear)
    );

    always #5 raw_clk = ~raw_clk;

    // uart TX side: busy rises 2 cycles after a strobe and lasts 10 cycles.
    initial begin
        int dly;
        int hold;
        dly = 0;
        hold = 0;
        model_busy = 1'b0;
        forever begin
            @(posedge raw_clk); #1;
            if (!model_en) begin
                model_busy = 1'b0; dly = 0; hold = 0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) model_busy = 1'b0;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin model_busy = 1'b1; hold = 10; end
            end else if (uart_tx_strobe) begin
                dly = 2;
            end
        end
    end

    // Record each strobe (rising) with its byte, and every cycle the RX ack is high.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(posedge raw_clk); #1;
            if (uart_tx_strobe && !prev) begin
                tx_seen.push_back(uart_tx_data);
                strobe_cnt++;
            end
            if (uart_rx_ready_clear) ack_cnt++;
            prev = uart_tx_strobe;
        end
    end

    task automatic tick();
        @(posedge raw_clk); #1;
    endtask

    task automatic push(input logic [7:0] b);
        tx_write = 1'b1; tx_write_data = b;
        tick();
        tx_write = 1'b0;
    endtask

    task automatic pop_rx();
        rx_read = 1'b1;
        tick();
        rx_read = 1'b0;
    endtask

    task automatic deliver(input logic [7:0] b);
        uart_rx_data = b; uart_rx_ready = 1'b1;
        for (int i = 0; i < 20 && !uart_rx_ready_clear; i++) tick();
        total++;
        if (uart_rx_ready_clear !== 1'b1) begin
            bad++; $display("FAIL deliver_ack byte=%0h got=%b exp=1", b, uart_rx_ready_clear);
        end
        uart_rx_ready = 1'b0;
        tick(); tick();
    endtask

    task automatic wait_tx_drained();
        for (int i = 0; i < 3000 && !(tx_count == 0 && !uart_tx_strobe && !uart_tx_busy); i++) tick();
        tick(); tick();
        total++;
        if (tx_count !== 5'd0 || uart_tx_busy !== 1'b0) begin
            bad++; $display("FAIL tx_drain_timeout got=%0d exp=0", tx_count);
        end
    endtask

    task automatic test_reset();
        int pulses;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        total++; if (tx_count !== 5'd0) begin bad++; $display("FAIL rst_tx_count got=%0d exp=0", tx_count); end
        total++; if (rx_count !== 5'd0) begin bad++; $display("FAIL rst_rx_count got=%0d exp=0", rx_count); end
        total++; if ({tx_empty, rx_empty, tx_full, rx_full} !== 4'b1100) begin
            bad++; $display("FAIL rst_status got=%b exp=1100", {tx_empty, rx_empty, tx_full, rx_full}); end
        total++; if ({tx_drop, rx_overflow} !== 2'b00) begin
            bad++; $display("FAIL rst_flags got=%b exp=00", {tx_drop, rx_overflow}); end
        total++; if (uart_tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%0h exp=0", uart_tx_data); end
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (uart_tx_strobe || uart_rx_ready_clear) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL idle_pulses got=%0d exp=0", pulses); end
    endtask

    task automatic test_tx_order();
        tx_seen.delete();
        strobe_cnt = 0;
        model_en = 1'b1;
        push(8'h41); push(8'h42); push(8'h43);
        total++; if (tx_count !== 5'd3) begin bad++; $display("FAIL order_count got=%0d exp=3", tx_count); end
        wait_tx_drained();
        total++; if (strobe_cnt != 3) begin bad++; $display("FAIL order_strobes got=%0d exp=3", strobe_cnt); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] e;
            e = 8'h41 + 8'(i);
            total++;
            if (tx_seen.size() <= i || tx_seen[i] !== e) begin
                bad++; $display("FAIL order_byte%0d got=%0h exp=%0h", i, (tx_seen.size() > i) ? tx_seen[i] : 8'hxx, e);
            end
        end
        total++; if (tx_empty !== 1'b1) begin bad++; $display("FAIL order_empty got=%b exp=1", tx_empty); end
    endtask

    task automatic test_tx_full();
        model_en = 1'b0;
        hold_busy = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) push(8'(i));
        total++; if (tx_full !== 1'b1 || tx_count !== 5'd16) begin
            bad++; $display("FAIL full_status got=%b/%0d exp=1/16", tx_full, tx_count); end
        total++; if (tx_drop !== 1'b0) begin bad++; $display("FAIL full_drop_early got=%b exp=0", tx_drop); end
        push(8'h10);
        total++; if (tx_drop !== 1'b1 || tx_count !== 5'd16) begin
            bad++; $display("FAIL full_drop got=%b/%0d exp=1/16", tx_drop, tx_count); end
        tx_seen.delete();
        hold_busy = 1'b0;
        model_en = 1'b1;
        wait_tx_drained();
        total++; if (tx_seen.size() != 16) begin bad++; $display("FAIL full_sent got=%0d exp=16", tx_seen.size()); end
        for (int i = 0; i < 16 && i < tx_seen.size(); i++) begin
            total++;
            if (tx_seen[i] !== 8'(i)) begin bad++; $display("FAIL full_byte%0d got=%0h exp=%0h", i, tx_seen[i], 8'(i)); end
        end
        total++; if (tx_drop !== 1'b1) begin bad++; $display("FAIL drop_sticky got=%b exp=1", tx_drop); end
        flag_clear = 1'b1; tick(); flag_clear = 1'b0;
        total++; if (tx_drop !== 1'b0) begin bad++; $display("FAIL drop_clear got=%b exp=0", tx_drop); end
        model_en = 1'b0;
    endtask

    task automatic test_rx_capture();
        int a0;
        a0 = ack_cnt;
        deliver(8'h55);
        deliver(8'hAA);
        total++; if (ack_cnt - a0 != 2) begin bad++; $display("FAIL rx_acks got=%0d exp=2", ack_cnt - a0); end
        total++; if (rx_count !== 5'd2) begin bad++; $display("FAIL rx_count2 got=%0d exp=2", rx_count); end
        total++; if (rx_read_data !== 8'h55) begin bad++; $display("FAIL rx_head0 got=%0h exp=55", rx_read_data); end
        pop_rx();
        total++; if (rx_read_data !== 8'hAA) begin bad++; $display("FAIL rx_head1 got=%0h exp=aa", rx_read_data); end
        pop_rx();
        total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL rx_empty got=%b exp=1", rx_empty); end
        pop_rx();
        total++; if (rx_count !== 5'd0) begin bad++; $display("FAIL rx_pop_empty got=%0d exp=0", rx_count); end
    endtask

    task automatic test_rx_overflow();
        int a0;
        for (int i = 0; i < 16; i++) deliver(8'h10 + 8'(i));
        total++; if (rx_full !== 1'b1 || rx_count !== 5'd16) begin
            bad++; $display("FAIL ovf_full got=%b/%0d exp=1/16", rx_full, rx_count); end
        a0 = ack_cnt;
        deliver(8'h99);
        total++; if (rx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", rx_overflow); end
        total++; if (ack_cnt - a0 != 1) begin bad++; $display("FAIL ovf_ack got=%0d exp=1", ack_cnt - a0); end
        total++; if (rx_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", rx_count); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rx_read_data !== 8'h10 + 8'(i)) begin bad++; $display("FAIL wrap_a%0d got=%0h exp=%0h", i, rx_read_data, 8'h10 + 8'(i)); end
            pop_rx();
        end
        for (int i = 0; i < 4; i++) deliver(8'h20 + 8'(i));
        for (int i = 0; i < 16; i++) begin
            logic [7:0] e;
            e = (i < 12) ? 8'h14 + 8'(i) : 8'h20 + 8'(i - 12);
            total++;
            if (rx_read_data !== e) begin bad++; $display("FAIL wrap_b%0d got=%0h exp=%0h", i, rx_read_data, e); end
            pop_rx();
        end
        total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", rx_empty); end
        flag_clear = 1'b1; tick(); flag_clear = 1'b0;
        total++; if (rx_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", rx_overflow); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) deliver(8'h60 + 8'(i));
        uart_rx_data = 8'h65; uart_rx_ready = 1'b1; rx_read = 1'b1;
        tick();
        rx_read = 1'b0;
        total++; if (uart_rx_ready_clear !== 1'b1) begin bad++; $display("FAIL sim_ack got=%b exp=1", uart_rx_ready_clear); end
        uart_rx_ready = 1'b0;
        total++; if (rx_count !== 5'd5) begin bad++; $display("FAIL sim_count got=%0d exp=5", rx_count); end
        total++; if (rx_read_data !== 8'h61) begin bad++; $display("FAIL sim_head got=%0h exp=61", rx_read_data); end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        hold_busy = 1'b0;
        model_en = 1'b0;
        push(8'h77);
        tick();
        total++; if (uart_tx_strobe !== 1'b1 || uart_tx_data !== 8'h77) begin
            bad++; $display("FAIL mid_strobe got=%b/%0h exp=1/77", uart_tx_strobe, uart_tx_data); end
        #2 reset = 1'b0;
        #1;
        total++; if (uart_tx_strobe !== 1'b0) begin bad++; $display("FAIL mid_async_strobe got=%b exp=0", uart_tx_strobe); end
        total++; if (tx_count !== 5'd0 || rx_count !== 5'd0) begin
            bad++; $display("FAIL mid_counts got=%0d/%0d exp=0/0", tx_count, rx_count); end
        @(negedge raw_clk) reset = 1'b1;
        repeat (3) tick();
        total++; if (uart_tx_strobe !== 1'b0 || tx_empty !== 1'b1) begin
            bad++; $display("FAIL mid_after got=%b/%b exp=0/1", uart_tx_strobe, tx_empty); end
    endtask

    initial begin
        reset = 1'b0;
        tx_write = 1'b0; tx_write_data = '0;
        rx_read = 1'b0; flag_clear = 1'b0;
        uart_rx_data = '0; uart_rx_ready = 1'b0;
        hold_busy = 1'b0; model_en = 1'b0;
        test_reset();
        test_tx_order();
        test_tx_full();
        test_rx_capture();
        test_rx_overflow();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
